// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read and output stream signals of the RAM stream reader
// master: the reader (drives busy/done/r_addr/out_*); slave: the environment (drives start/base_addr/length/abort/r_data/out_ready)
interface ram_stream_reader_if #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 11
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS:0]   length;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] r_addr;
  logic [WIDTH-1:0]     r_data;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic                 out_ready;
  modport master (
    input  start, base_addr, length, abort, r_data, out_ready,
    output busy, done, r_addr, out_valid, out_data, out_last
  );
  modport slave (
    output start, base_addr, length, abort, r_data, out_ready,
    input  busy, done, r_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps a RAM address range and streams the words out in order over valid/ready
// ports: clk, rst (sync, active high); bus = ram_stream_reader_if.master (command, RAM read port, output stream)
module ram_stream_reader #(
  parameter int WIDTH      = 64,
  parameter int ADDR_BITS  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  ram_stream_reader_if.master bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [0:0]            state;
  logic [ADDR_BITS-1:0]  issue_addr;
  logic [ADDR_BITS:0]    issue_left;
  logic [ADDR_BITS:0]    accept_left;
  logic                  pend1;
  logic                  pend2;
  logic                  last1;
  logic                  last2;
  logic [WIDTH-1:0]      fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           in_use;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  go;
  logic                  finish;
  logic                  kill;
  // in_use counts FIFO entries plus reads still in the RAM pipeline, so the FIFO can never overflow
  always_comb begin
    in_use = count + (PW+1)'(pend1) + (PW+1)'(pend2);
    issue  = state == RUN && issue_left != '0 && in_use < (PW+1)'(FIFO_DEPTH);
    push   = pend2;
    pop    = bus.out_valid && bus.out_ready;
    kill   = state == RUN && bus.abort;
    go     = state == IDLE && bus.start && !bus.abort;
    finish = state == RUN && pop && accept_left == (ADDR_BITS+1)'(1);
  end
  assign bus.busy      = state == RUN;
  assign bus.out_valid = count != '0;
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_last  = fifo_last[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_addr  <= '0;
      issue_left  <= '0;
      accept_left <= '0;
      pend1       <= 1'b0;
      pend2       <= 1'b0;
      last1       <= 1'b0;
      last2       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_last   <= '0;
      bus.r_addr  <= '0;
      bus.done    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else if (kill) begin
      state    <= IDLE;
      pend1    <= 1'b0;
      pend2    <= 1'b0;
      last1    <= 1'b0;
      last2    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      pend1    <= issue;
      pend2    <= pend1;
      // the last flag rides alongside the read so it lands on the final pushed entry
      last1    <= issue && issue_left == (ADDR_BITS+1)'(1);
      last2    <= last1;
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (issue) begin
        bus.r_addr <= issue_addr;
        issue_addr <= issue_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      if (push) begin
        fifo_data[wr_ptr] <= bus.r_data;
        fifo_last[wr_ptr] <= last2;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        accept_left <= accept_left - 1'b1;
      end
      if (go && bus.length != '0) begin
        state       <= RUN;
        issue_addr  <= bus.base_addr;
        issue_left  <= bus.length;
        accept_left <= bus.length;
      end
      if (go && bus.length == '0) bus.done <= 1'b1;
      if (finish) begin
        state    <= IDLE;
        bus.done <= 1'b1;
      end
    end
  end
endmodule
